// File: rtl/ar_uid_pkg.sv
// ar_uid_pkg: shared state type and lowest-free-entry search for the AR UID allocator.
package ar_uid_pkg;
  localparam int UA_MAX_UIDS = 256;
  typedef enum logic {UA_IDLE, UA_GRANT} ua_state_t;
  function automatic int lowest_free(input logic [UA_MAX_UIDS-1:0] busy);
    lowest_free = 0;
    for (int i = UA_MAX_UIDS - 1; i >= 0; i--) if (!busy[i]) lowest_free = i;
  endfunction
endpackage

// File: rtl/ar_uid_allocator_prio_enc.sv
// uid_prio_enc: lowest-set-bit encoder over the free-entry vector, with any-set flag.
module uid_prio_enc import ar_uid_pkg::*; #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [UA_MAX_UIDS-1:0] busy_ext;
  always_comb begin
    busy_ext = '1;
    busy_ext[N-1:0] = ~req;
  end
  assign idx = IW'(lowest_free(busy_ext));
  assign any = |req;
endmodule

// File: rtl/ar_uid_allocator.sv
// ar_uid_allocator: hands out UIDs for AR requests, remembers the ARID, frees on RLAST.
// Define AR_UID_PER_ID_LIMIT_EN to cap outstanding UIDs per original ARID at MAX_PER_ID.
module ar_uid_allocator import ar_uid_pkg::*; #(
  parameter int ID_WIDTH   = 4,
  parameter int UID_WIDTH  = 8,
  parameter int NUM_UIDS   = 16,
  parameter int MAX_PER_ID = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_req,
  input  logic [ID_WIDTH-1:0]             alloc_in_id,
  output logic                            alloc_gnt,
  output logic [UID_WIDTH-1:0]            unique_id,
  input  logic                            rel_valid,
  input  logic [UID_WIDTH-1:0]            rel_uid,
  input  logic [UID_WIDTH-1:0]            lkp_uid,
  output logic [ID_WIDTH-1:0]             lkp_orig_id,
  output logic                            lkp_hit,
  output logic [$clog2(NUM_UIDS+1)-1:0]   free_count,
  output logic                            rel_err
);
  localparam int IW = $clog2(NUM_UIDS);
  localparam int CW = $clog2(NUM_UIDS + 1);
  ua_state_t             state_q, state_d;
  logic [NUM_UIDS-1:0]   busy_q, busy_d;
  logic [ID_WIDTH-1:0]   orig_q [NUM_UIDS];
  logic [ID_WIDTH-1:0]   orig_d [NUM_UIDS];
  logic [IW-1:0]         gidx_q, gidx_d, free_idx, rel_idx, lkp_idx;
  logic                  rel_err_q, rel_err_d, free_any, can_alloc, do_alloc, do_rel;
  assign rel_idx = rel_uid[IW-1:0];
  assign lkp_idx = lkp_uid[IW-1:0];
  uid_prio_enc #(.N(NUM_UIDS), .IW(IW)) u_enc (.req(~busy_q), .idx(free_idx), .any(free_any));
  assign do_alloc = (state_q == UA_IDLE) && alloc_req && can_alloc;
  assign do_rel   = rel_valid && (int'(rel_uid) < NUM_UIDS) && busy_q[rel_idx];
`ifdef AR_UID_PER_ID_LIMIT_EN
  localparam int PW = $clog2(MAX_PER_ID + 1);
  logic [PW-1:0] cnt_q [2**ID_WIDTH];
  logic [PW-1:0] cnt_d [2**ID_WIDTH];
  assign can_alloc = free_any && (cnt_q[alloc_in_id] < PW'(MAX_PER_ID));
  // Same-ID alloc and release in one cycle cancel through sequential update.
  always_comb begin
    cnt_d = cnt_q;
    if (do_alloc) cnt_d[alloc_in_id] = cnt_d[alloc_in_id] + PW'(1);
    if (do_rel) cnt_d[orig_q[rel_idx]] = cnt_d[orig_q[rel_idx]] - PW'(1);
  end
  always_ff @(posedge clk) cnt_q <= rst ? '{default: '0} : cnt_d;
`else
  assign can_alloc = free_any;
`endif
  // Allocation picks from the pre-release vector, so a freed entry waits one cycle.
  always_comb begin
    busy_d = busy_q;
    orig_d = orig_q;
    if (do_rel) busy_d[rel_idx] = 1'b0;
    if (do_alloc) begin
      busy_d[free_idx] = 1'b1;
      orig_d[free_idx] = alloc_in_id;
    end
    gidx_d    = do_alloc ? free_idx : gidx_q;
    state_d   = do_alloc ? UA_GRANT : (state_q == UA_GRANT && !alloc_req) ? UA_IDLE : state_q;
    rel_err_d = rel_err_q | (rel_valid & ~do_rel);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UA_IDLE;
      busy_q    <= '0;
      orig_q    <= '{default: '0};
      gidx_q    <= '0;
      rel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      orig_q    <= orig_d;
      gidx_q    <= gidx_d;
      rel_err_q <= rel_err_d;
    end
  end
  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_UIDS; i++) free_count = free_count + CW'(!busy_q[i]);
  end
  assign alloc_gnt   = state_q == UA_GRANT;
  assign unique_id   = alloc_gnt ? UID_WIDTH'(gidx_q) : '0;
  assign lkp_hit     = (int'(lkp_uid) < NUM_UIDS) && busy_q[lkp_idx];
  assign lkp_orig_id = lkp_hit ? orig_q[lkp_idx] : '0;
  assign rel_err     = rel_err_q;
endmodule
